// File: rtl/fifo_uart_tx.sv
// Purpose: drains a byte FIFO one word at a time and serialises each word as a UART frame
//          (start bit, LSB-first data, optional parity, one stop bit).
// Latency: tx falls 2 cycles after the fifo_rd strobe rises. Each frame lasts
//          (2 + DATA_WIDTH + PARITY_EN) * CLKS_PER_BIT cycles.
// Backpressure: a new frame starts only in IDLE with en=1 and fifo_empty=0, so the FIFO is never underflowed.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   en         - permits starting a new frame (sampled only in IDLE)
//   fifo_empty - FIFO empty flag
//   fifo_data  - FIFO registered read data, valid the cycle after fifo_rd
//   fifo_rd    - one-cycle read strobe per frame
//   tx         - serial line, idles high
//   busy       - high in every state except IDLE
//   byte_done  - one-cycle pulse after each completed frame
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  byte_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  shift;
  logic [DATA_WIDTH-1:0]  shift_nxt;
  logic                   parity_bit;
  logic                   baud_last;

  assign baud_last = (baud_cnt == BAUD_LAST);
  // Next data bit is taken from the already-shifted word so DATA_WIDTH=1 stays in range.
  assign shift_nxt = shift >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      fifo_rd    <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      byte_done  <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (en && !fifo_empty) begin
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: begin
          // FIFO presents the word on the edge that closes this cycle.
          fifo_rd <= 1'b0;
          state   <= LOAD;
        end
        LOAD: begin
          // Parity is computed from the captured word, so later FIFO activity cannot disturb it.
          shift      <= fifo_data;
          parity_bit <= (^fifo_data) ^ (PARITY_ODD != 0);
          tx         <= 1'b0;
          baud_cnt   <= '0;
          state      <= START;
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                tx    <= parity_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              shift   <= shift_nxt;
              tx      <= shift_nxt[0];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt  <= '0;
            busy      <= 1'b0;
            byte_done <= 1'b1;
            state     <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a behavioural 16-deep FIFO feeds the main instance, a frame
// monitor decodes tx cycle by cycle against a queue of expected frames, and two
// parity-enabled instances (even and odd) are driven directly with a fixed byte.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en  = 1'b0;

  // Behavioural FIFO with registered read data.
  logic [7:0] mem [16];
  int         wp = 0;
  int         rp = 0;
  logic [7:0] f_dout = 8'h00;
  logic       underflow = 1'b0;
  logic       fifo_empty;
  assign fifo_empty = (wp == rp);

  logic u0_rd, u0_tx, u0_busy, u0_done;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(f_dout),
    .fifo_rd(u0_rd), .tx(u0_tx), .busy(u0_busy), .byte_done(u0_done)
  );

  always @(posedge clk) begin
    if (u0_rd) begin
      if (wp == rp) underflow <= 1'b1;
      else begin
        f_dout <= mem[rp % 16];
        rp     <= rp + 1;
      end
    end
  end

  // Parity instances share a constant data word and a bench-driven empty flag.
  logic       p_empty = 1'b1;
  logic [7:0] p_data  = 8'hB2;
  logic p1_rd, p1_tx, p1_busy, p1_done;
  logic p2_rd, p2_tx, p2_busy, p2_done;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(p_empty), .fifo_data(p_data),
    .fifo_rd(p1_rd), .tx(p1_tx), .busy(p1_busy), .byte_done(p1_done)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(p_empty), .fifo_data(p_data),
    .fifo_rd(p2_rd), .tx(p2_tx), .busy(p2_busy), .byte_done(p2_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input bit ok, input string name, input int act, input int expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [9:0] mkframe(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  // Strobe bookkeeping on the main instance.
  int   rd_pulses = 0;
  int   done_pulses = 0;
  int   viol = 0;
  time  rd_rise_t = 0;
  logic rd_prev = 1'b0;
  logic bd_prev = 1'b0;

  always @(negedge clk) begin
    if (u0_rd && !rd_prev) begin
      rd_pulses++;
      rd_rise_t = $time;
    end
    if (u0_rd && rd_prev) viol++;
    if (u0_rd && fifo_empty) viol++;
    if (u0_done && !bd_prev) done_pulses++;
    rd_prev = u0_rd;
    bd_prev = u0_done;
  end

  // Scoreboard of expected 10-bit line images (bit k = line value during bit time k).
  logic [9:0] sb_q [$];
  int         gap_q [$];

  initial begin : mon
    logic       prev;
    int         idle_run;
    logic [9:0] exp_f;
    int         bad;
    bit         aborted;
    prev = 1'b1;
    idle_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
        idle_run = 0;
      end else if (prev && !u0_tx) begin
        gap_q.push_back(idle_run);
        check(($time - rd_rise_t) == 20, "tx_fall_latency", int'($time - rd_rise_t), 20);
        if (sb_q.size() == 0) begin
          check(1'b0, "unexpected_frame", 1, 0);
          prev = 1'b0;
          idle_run = 0;
        end else begin
          exp_f = sb_q.pop_front();
          bad = 0;
          aborted = 1'b0;
          for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            if (u0_tx !== exp_f[k/4]) bad++;
          end
          if (aborted) begin
            prev = 1'b1;
            idle_run = 0;
          end else begin
            check(bad == 0, "frame_bits_bad_cycles", bad, 0);
            @(negedge clk);
            check(u0_done === 1'b1 && u0_tx === 1'b1, "byte_done_after_stop", int'(u0_done), 1);
            prev = 1'b1;
            idle_run = 1;
          end
        end
      end else begin
        if (u0_tx) idle_run++;
        prev = u0_tx;
      end
    end
  end

  task automatic fifo_write(input logic [7:0] d);
    mem[wp % 16] = d;
    wp++;
  endtask

  task automatic wait_done(input int target, input int lim, input string name);
    int i = 0;
    while (done_pulses < target && i < lim) begin
      @(negedge clk);
      i++;
    end
    check(done_pulses >= target, name, done_pulses, target);
  endtask

  task automatic wait_fall(input int lim, input string name);
    int i = 0;
    while (u0_tx !== 1'b0 && i < lim) begin
      @(negedge clk);
      i++;
    end
    check(u0_tx === 1'b0, name, int'(u0_tx), 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t tab [6];

  initial begin : main
    int         bad, bad_o, base, rd0, i;
    logic [10:0] pe, po;

    tab[0] = '{8'hA1, 10'h342};
    tab[1] = '{8'hB2, 10'h364};
    tab[2] = '{8'hC3, 10'h386};
    tab[3] = '{8'h00, 10'h200};
    tab[4] = '{8'hFF, 10'h3FE};
    tab[5] = '{8'h55, 10'h2AA};

    // Reset held with a non-empty FIFO and en high: outputs stay idle.
    en = 1'b1;
    @(negedge clk);
    fifo_write(8'h11);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (u0_tx !== 1'b1 || u0_busy !== 1'b0 || u0_rd !== 1'b0 || u0_done !== 1'b0) bad++;
    end
    check(bad == 0, "reset_hold_outputs", bad, 0);
    sb_q.push_back(mkframe(8'h11));
    base = done_pulses;
    rd0 = rd_pulses;
    rst = 1'b0;
    wait_done(base + 1, 200, "reset_release_frame_done");
    repeat (2) @(negedge clk);
    check(rd_pulses - rd0 == 1, "reset_release_rd_pulses", rd_pulses - rd0, 1);

    // Single-byte table.
    for (int t = 0; t < 6; t++) begin
      rd0 = rd_pulses;
      base = done_pulses;
      fifo_write(tab[t].data);
      sb_q.push_back(tab[t].frame);
      wait_done(base + 1, 200, "single_frame_done");
      repeat (2) @(negedge clk);
      check(rd_pulses - rd0 == 1, "single_rd_pulses", rd_pulses - rd0, 1);
      check(wp == rp, "single_fifo_drained", wp - rp, 0);
      check(u0_busy === 1'b0, "single_busy_after", int'(u0_busy), 0);
    end

    // Burst of three: in order, 3 idle cycles between frames.
    en = 1'b0;
    @(negedge clk);
    gap_q.delete();
    rd0 = rd_pulses;
    base = done_pulses;
    fifo_write(8'hA1); sb_q.push_back(mkframe(8'hA1));
    fifo_write(8'hB2); sb_q.push_back(mkframe(8'hB2));
    fifo_write(8'hC3); sb_q.push_back(mkframe(8'hC3));
    en = 1'b1;
    wait_done(base + 3, 600, "burst_done");
    repeat (2) @(negedge clk);
    check(rd_pulses - rd0 == 3, "burst_rd_pulses", rd_pulses - rd0, 3);
    check(gap_q.size() == 3, "burst_frame_count", gap_q.size(), 3);
    check(gap_q.size() == 3 && gap_q[1] == 3, "burst_gap_1", (gap_q.size() > 1) ? gap_q[1] : -1, 3);
    check(gap_q.size() == 3 && gap_q[2] == 3, "burst_gap_2", (gap_q.size() > 2) ? gap_q[2] : -1, 3);

    // en gating.
    en = 1'b0;
    rd0 = rd_pulses;
    fifo_write(8'hC3);
    fifo_write(8'h55);
    repeat (100) @(negedge clk);
    check(rd_pulses - rd0 == 0, "en_low_no_rd", rd_pulses - rd0, 0);
    check(u0_busy === 1'b0, "en_low_not_busy", int'(u0_busy), 0);
    sb_q.push_back(mkframe(8'hC3));
    base = done_pulses;
    en = 1'b1;
    wait_fall(50, "en_high_frame_start");
    repeat (8) @(negedge clk);
    en = 1'b0;
    wait_done(base + 1, 200, "en_drop_frame_done");
    repeat (20) @(negedge clk);
    check(rd_pulses - rd0 == 1, "en_drop_rd_pulses", rd_pulses - rd0, 1);
    check(wp - rp == 1, "en_drop_byte_left", wp - rp, 1);
    sb_q.push_back(mkframe(8'h55));
    base = done_pulses;
    en = 1'b1;
    wait_done(base + 1, 200, "en_resume_done");
    repeat (2) @(negedge clk);

    // Parity: 0xB2 has four ones -> even parity 0, odd parity 1, 44-cycle frame.
    pe = {1'b1, 1'b0, 8'hB2, 1'b0};
    po = {1'b1, 1'b1, 8'hB2, 1'b0};
    p_empty = 1'b0;
    i = 0;
    while (p1_rd !== 1'b1 && i < 20) begin
      @(negedge clk);
      i++;
    end
    check(p1_rd === 1'b1 && p2_rd === 1'b1, "parity_rd_strobe", int'(p1_rd), 1);
    p_empty = 1'b1;
    i = 0;
    while (p1_tx !== 1'b0 && i < 20) begin
      @(negedge clk);
      i++;
    end
    bad = 0;
    bad_o = 0;
    for (int k = 0; k < 44; k++) begin
      if (k > 0) @(negedge clk);
      if (p1_tx !== pe[k/4]) bad++;
      if (p2_tx !== po[k/4]) bad_o++;
    end
    check(bad == 0, "parity_even_frame_bad_cycles", bad, 0);
    check(bad_o == 0, "parity_odd_frame_bad_cycles", bad_o, 0);
    @(negedge clk);
    check(p1_done === 1'b1 && p2_done === 1'b1, "parity_byte_done_at_44", int'(p1_done), 1);
    repeat (4) @(negedge clk);

    // Reset during data bit 3 of 0xA1 with 0xB2 queued.
    rd0 = rd_pulses;
    fifo_write(8'hA1); sb_q.push_back(mkframe(8'hA1));
    fifo_write(8'hB2); sb_q.push_back(mkframe(8'hB2));
    wait_fall(50, "rst_test_frame_start");
    repeat (17) @(negedge clk);
    #2;
    check(u0_busy === 1'b1 && u0_tx === 1'b0, "pre_rst_in_bit3", int'(u0_tx), 0);
    rst = 1'b1;
    #1;
    check(u0_tx === 1'b1, "async_rst_tx", int'(u0_tx), 1);
    check(u0_busy === 1'b0, "async_rst_busy", int'(u0_busy), 0);
    repeat (3) @(negedge clk);
    base = done_pulses;
    rst = 1'b0;
    wait_done(base + 1, 200, "post_rst_frame_done");
    repeat (4) @(negedge clk);
    check(rd_pulses - rd0 == 2, "post_rst_rd_pulses", rd_pulses - rd0, 2);
    check(wp == rp, "post_rst_fifo_drained", wp - rp, 0);

    // Global properties.
    check(viol == 0, "rd_strobe_violations", viol, 0);
    check(underflow == 1'b0, "fifo_underflow", int'(underflow), 0);
    check(sb_q.size() == 0, "scoreboard_leftover", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
